// File: rtl/fmcw_ramp_sync.sv
// fmcw_ramp_sync: derives per-chirp capture timing (start strobe, sample window,
// chirp index, frame done) from the synthesizer MUXOUT ramp-status pin.
module fmcw_ramp_sync #(
   parameter int SETTLE_CYCLES    = 64,
   parameter int SAMPLE_CYCLES    = 2048,
   parameter int CHIRPS_PER_FRAME = 16,
   parameter int TIMEOUT_CYCLES   = 8192,
   localparam int CW = (CHIRPS_PER_FRAME > 1) ? $clog2(CHIRPS_PER_FRAME) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          config_done,
   input  logic          arm,
   input  logic          muxout,
   output logic          busy,
   output logic          chirp_start,
   output logic          sample_en,
   output logic [CW-1:0] chirp_idx,
   output logic          frame_done,
   output logic [1:0]    err
);
   localparam int TMAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ?
                         ((SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES) :
                         ((SAMPLE_CYCLES > TIMEOUT_CYCLES) ? SAMPLE_CYCLES : TIMEOUT_CYCLES);
   localparam int TW = $clog2(TMAX + 1);
   localparam logic [TW-1:0] SETTLE_END  = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] SAMPLE_END  = TW'(SAMPLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] LAST_CHIRP  = CW'(CHIRPS_PER_FRAME - 1);

   typedef enum logic [1:0] {IDLE, WAIT_RAMP, SETTLE, SAMPLE} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    sync;
   logic          ramp_edge;

   // two synchronizer flops, a third for edge history; the edge itself is registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync      <= '0;
         ramp_edge <= 1'b0;
      end else begin
         sync      <= {sync[1:0], muxout};
         ramp_edge <= sync[1] & ~sync[2];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         timer       <= '0;
         busy        <= 1'b0;
         chirp_start <= 1'b0;
         sample_en   <= 1'b0;
         chirp_idx   <= '0;
         frame_done  <= 1'b0;
         err         <= '0;
      end else begin
         chirp_start <= 1'b0;
         frame_done  <= 1'b0;
         if (state == IDLE) begin
            if (arm && config_done) begin
               state     <= WAIT_RAMP;
               busy      <= 1'b1;
               chirp_idx <= '0;
               err       <= '0;
               timer     <= '0;
            end
         end else if (!config_done) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sample_en <= 1'b0;
         end else if (state == WAIT_RAMP) begin
            // an edge on the terminal cycle still counts as a ramp
            if (ramp_edge) begin
               chirp_start <= 1'b1;
               timer       <= '0;
               state       <= SETTLE;
            end else if (timer == TIMEOUT_END) begin
               err[0] <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end else begin
               timer <= timer + 1'b1;
            end
         end else if (ramp_edge) begin
            err[1]    <= 1'b1;
            sample_en <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
         end else if (state == SETTLE) begin
            if (timer == SETTLE_END) begin
               timer     <= '0;
               sample_en <= 1'b1;
               state     <= SAMPLE;
            end else begin
               timer <= timer + 1'b1;
            end
         end else begin
            if (timer == SAMPLE_END) begin
               sample_en <= 1'b0;
               timer     <= '0;
               if (chirp_idx == LAST_CHIRP) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  chirp_idx <= chirp_idx + 1'b1;
                  state     <= WAIT_RAMP;
               end
            end else begin
               timer <= timer + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_fmcw_ramp_sync.sv
// tb_fmcw_ramp_sync: scoreboard bench; instance a is the nominal build,
// instance b the single-cycle boundary build with a short timeout.
module tb_fmcw_ramp_sync;
   logic clk = 0, rst_n = 0;
   logic cfg_a = 0, arm_a = 0, mux_a = 0, cfg_b = 0, arm_b = 0, mux_b = 0;
   logic busy_a, cs_a, se_a, fd_a, busy_b, cs_b, se_b, fd_b;
   logic [1:0] idx_a, err_a, err_b;
   logic [0:0] idx_b;
   int cyc = 0, checks = 0, fails = 0;
   int e_cs[$], e_idx[$], e_wst[$], e_wlen[$], e_fd[$];
   int a_cs[$], a_idx[$], a_wst[$], a_wlen[$], a_fd[$];
   int b_cs[$], b_wst[$], b_wlen[$], b_fd[$];
   int a_st = 0, a_len = 0, b_st = 0, b_len = 0;
   logic a_prev = 0, b_prev = 0;

   fmcw_ramp_sync #(.SETTLE_CYCLES(4), .SAMPLE_CYCLES(8), .CHIRPS_PER_FRAME(3), .TIMEOUT_CYCLES(64)) u_a (
      .clk(clk), .rst_n(rst_n), .config_done(cfg_a), .arm(arm_a), .muxout(mux_a), .busy(busy_a),
      .chirp_start(cs_a), .sample_en(se_a), .chirp_idx(idx_a), .frame_done(fd_a), .err(err_a));

   fmcw_ramp_sync #(.SETTLE_CYCLES(1), .SAMPLE_CYCLES(1), .CHIRPS_PER_FRAME(1), .TIMEOUT_CYCLES(16)) u_b (
      .clk(clk), .rst_n(rst_n), .config_done(cfg_b), .arm(arm_b), .muxout(mux_b), .busy(busy_b),
      .chirp_start(cs_b), .sample_en(se_b), .chirp_idx(idx_b), .frame_done(fd_b), .err(err_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (cs_a) begin a_cs.push_back(cyc); a_idx.push_back(int'(idx_a)); end
      if (se_a && !a_prev) begin a_st = cyc; a_len = 0; end
      if (se_a) a_len++;
      if (!se_a && a_prev) begin a_wst.push_back(a_st); a_wlen.push_back(a_len); end
      if (fd_a) a_fd.push_back(cyc);
      a_prev = se_a;
      if (cs_b) b_cs.push_back(cyc);
      if (se_b && !b_prev) begin b_st = cyc; b_len = 0; end
      if (se_b) b_len++;
      if (!se_b && b_prev) begin b_wst.push_back(b_st); b_wlen.push_back(b_len); end
      if (fd_b) b_fd.push_back(cyc);
      b_prev = se_b;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr;
      e_cs.delete(); e_idx.delete(); e_wst.delete(); e_wlen.delete(); e_fd.delete();
      a_cs.delete(); a_idx.delete(); a_wst.delete(); a_wlen.delete(); a_fd.delete();
      b_cs.delete(); b_wst.delete(); b_wlen.delete(); b_fd.delete();
   endtask

   task automatic test_reset;
      rst_n = 0;
      tick(2);
      checks++;
      if ({busy_a, cs_a, se_a, idx_a, fd_a, err_a} !== 8'd0) begin
         fails++; $display("FAIL reset_a: got %b required 0", {busy_a, cs_a, se_a, idx_a, fd_a, err_a});
      end
      checks++;
      if ({busy_b, cs_b, se_b, idx_b, fd_b, err_b} !== 7'd0) begin
         fails++; $display("FAIL reset_b: got %b required 0", {busy_b, cs_b, se_b, idx_b, fd_b, err_b});
      end
      rst_n = 1;
      tick(2);
      clr();
   endtask

   task automatic test_nominal;
      int c;
      clr();
      cfg_a = 1; arm_a = 1; tick(1); arm_a = 0;
      checks++;
      if (busy_a !== 1'b1) begin fails++; $display("FAIL nom_busy: got %b required 1", busy_a); end
      tick(5);
      for (int k = 0; k < 3; k++) begin
         mux_a = 1; c = cyc;
         e_cs.push_back(c + 4); e_idx.push_back(k); e_wst.push_back(c + 8); e_wlen.push_back(8);
         if (k == 2) e_fd.push_back(c + 16);
         tick(4); mux_a = 0; tick(36);
      end
      checks++;
      if (a_cs.size() != 3) begin fails++; $display("FAIL nom_chirps: got %0d required 3", a_cs.size()); end
      for (int k = 0; k < 3; k++) begin
         int e = e_cs.pop_front(), ei = e_idx.pop_front(), ws = e_wst.pop_front(), wl = e_wlen.pop_front();
         int o = (k < a_cs.size()) ? a_cs[k] : -1, oi = (k < a_idx.size()) ? a_idx[k] : -1;
         int os = (k < a_wst.size()) ? a_wst[k] : -1, ol = (k < a_wlen.size()) ? a_wlen[k] : -1;
         checks += 4;
         if (o !== e) begin fails++; $display("FAIL nom_start_cyc[%0d]: got %0d required %0d", k, o, e); end
         if (oi !== ei) begin fails++; $display("FAIL nom_idx[%0d]: got %0d required %0d", k, oi, ei); end
         if (os !== ws) begin fails++; $display("FAIL nom_win_start[%0d]: got %0d required %0d", k, os, ws); end
         if (ol !== wl) begin fails++; $display("FAIL nom_win_len[%0d]: got %0d required %0d", k, ol, wl); end
      end
      begin
         int e = e_fd.pop_front(), o = (a_fd.size() == 1) ? a_fd[0] : -1;
         checks++;
         if (o !== e) begin fails++; $display("FAIL nom_frame_done: got %0d (n=%0d) required %0d", o, a_fd.size(), e); end
      end
      checks++;
      if ({busy_a, err_a} !== 3'b000) begin fails++; $display("FAIL nom_end: busy/err got %b required 000", {busy_a, err_a}); end
   endtask

   task automatic test_timeout;
      int t, n;
      clr();
      mux_a = 0; arm_a = 1; tick(1); arm_a = 0; t = cyc;
      n = 0;
      while (busy_a && n < 200) begin tick(1); n++; end
      checks++;
      if (cyc - t !== 64) begin fails++; $display("FAIL to_delay: got %0d required 64", cyc - t); end
      checks++;
      if (err_a !== 2'b01) begin fails++; $display("FAIL to_err: got %b required 01", err_a); end
      checks++;
      if (a_cs.size() != 0) begin fails++; $display("FAIL to_no_chirp: got %0d required 0", a_cs.size()); end
      arm_a = 1; tick(1); arm_a = 0;
      checks++;
      if ({busy_a, err_a} !== 3'b100) begin fails++; $display("FAIL to_rearm: busy/err got %b required 100", {busy_a, err_a}); end
      cfg_a = 0; tick(1);
      checks++;
      if ({busy_a, err_a} !== 3'b000) begin fails++; $display("FAIL to_abort: busy/err got %b required 000", {busy_a, err_a}); end
      cfg_a = 1; tick(2);
   endtask

   task automatic test_overrun;
      int c;
      clr();
      arm_a = 1; tick(1); arm_a = 0; tick(3);
      mux_a = 1; c = cyc;
      e_cs.push_back(c + 4); e_wst.push_back(c + 8); e_wlen.push_back(4);
      tick(4); mux_a = 0; tick(4);
      mux_a = 1; tick(4); mux_a = 0; tick(10);
      begin
         int e = e_cs.pop_front(), ws = e_wst.pop_front(), wl = e_wlen.pop_front();
         int o = (a_cs.size() == 1) ? a_cs[0] : -1;
         int os = (a_wst.size() == 1) ? a_wst[0] : -1, ol = (a_wlen.size() == 1) ? a_wlen[0] : -1;
         checks += 3;
         if (o !== e) begin fails++; $display("FAIL ovr_start: got %0d required %0d", o, e); end
         if (os !== ws) begin fails++; $display("FAIL ovr_win_start: got %0d required %0d", os, ws); end
         if (ol !== wl) begin fails++; $display("FAIL ovr_win_len: got %0d required %0d", ol, wl); end
      end
      checks++;
      if ({busy_a, err_a} !== 3'b010) begin fails++; $display("FAIL ovr_err: busy/err got %b required 010", {busy_a, err_a}); end
      checks++;
      if (a_fd.size() != 0) begin fails++; $display("FAIL ovr_no_fd: got %0d required 0", a_fd.size()); end
   endtask

   task automatic test_gating;
      clr();
      cfg_a = 0; arm_a = 1; tick(1); arm_a = 0;
      checks++;
      if (busy_a !== 1'b0) begin fails++; $display("FAIL gate_cfg: busy got %b required 0", busy_a); end
      cfg_a = 1; mux_a = 1; tick(4); mux_a = 0; tick(12);
      checks++;
      if (a_cs.size() != 0 || busy_a !== 1'b0) begin
         fails++; $display("FAIL gate_pre_arm: chirps %0d busy %b required 0 0", a_cs.size(), busy_a);
      end
      arm_a = 1; tick(1); arm_a = 0; tick(2);
      mux_a = 1; tick(4); mux_a = 0; tick(20);
      arm_a = 1; tick(1); arm_a = 0;
      checks++;
      if ({busy_a, idx_a} !== 3'b101) begin fails++; $display("FAIL gate_rearm: busy/idx got %b required 101", {busy_a, idx_a}); end
      cfg_a = 0; tick(1); cfg_a = 1; tick(1);
   endtask

   task automatic test_abort;
      clr();
      arm_a = 1; tick(1); arm_a = 0; tick(2);
      mux_a = 1; tick(4); mux_a = 0; tick(6);
      checks++;
      if (se_a !== 1'b1) begin fails++; $display("FAIL abort_in_window: sample_en got %b required 1", se_a); end
      cfg_a = 0; tick(1);
      checks++;
      if ({se_a, busy_a} !== 2'b00) begin fails++; $display("FAIL abort_cfg: sample_en/busy got %b required 00", {se_a, busy_a}); end
      cfg_a = 1; tick(5);
      checks++;
      if (a_fd.size() != 0 || err_a !== 2'b00) begin
         fails++; $display("FAIL abort_cfg_after: fd %0d err %b required 0 00", a_fd.size(), err_a);
      end
      clr();
      arm_a = 1; tick(1); arm_a = 0; tick(2);
      mux_a = 1; tick(4); mux_a = 0; tick(1);
      rst_n = 0; tick(1);
      checks++;
      if ({busy_a, cs_a, se_a, idx_a, fd_a, err_a} !== 8'd0) begin
         fails++; $display("FAIL abort_rst: got %b required 0", {busy_a, cs_a, se_a, idx_a, fd_a, err_a});
      end
      rst_n = 1; tick(12);
      checks++;
      if (a_cs.size() != 1 || a_wst.size() != 0 || a_fd.size() != 0) begin
         fails++; $display("FAIL abort_rst_after: chirps %0d windows %0d fd %0d required 1 0 0", a_cs.size(), a_wst.size(), a_fd.size());
      end
   endtask

   task automatic test_boundary;
      int c, t;
      clr();
      cfg_b = 1; arm_b = 1; tick(1); arm_b = 0; tick(2);
      mux_b = 1; c = cyc;
      e_cs.push_back(c + 4); e_wst.push_back(c + 5); e_wlen.push_back(1); e_fd.push_back(c + 6);
      tick(4); mux_b = 0; tick(8);
      begin
         int e = e_cs.pop_front(), ws = e_wst.pop_front(), wl = e_wlen.pop_front(), ef = e_fd.pop_front();
         int o = (b_cs.size() == 1) ? b_cs[0] : -1, of = (b_fd.size() == 1) ? b_fd[0] : -1;
         int os = (b_wst.size() == 1) ? b_wst[0] : -1, ol = (b_wlen.size() == 1) ? b_wlen[0] : -1;
         checks += 4;
         if (o !== e) begin fails++; $display("FAIL bnd_start: got %0d required %0d", o, e); end
         if (os !== ws) begin fails++; $display("FAIL bnd_win_start: got %0d required %0d", os, ws); end
         if (ol !== wl) begin fails++; $display("FAIL bnd_win_len: got %0d required %0d", ol, wl); end
         if (of !== ef) begin fails++; $display("FAIL bnd_frame_done: got %0d required %0d", of, ef); end
      end
      checks++;
      if ({busy_b, err_b} !== 3'b000) begin fails++; $display("FAIL bnd_end: busy/err got %b required 000", {busy_b, err_b}); end
      clr();
      arm_b = 1; tick(1); arm_b = 0; t = cyc;
      tick(12);
      mux_b = 1; e_cs.push_back(t + 16);
      tick(4); mux_b = 0; tick(8);
      begin
         int e = e_cs.pop_front(), o = (b_cs.size() == 1) ? b_cs[0] : -1;
         checks++;
         if (o !== e) begin fails++; $display("FAIL bnd_edge_at_timeout: got %0d required %0d", o, e); end
      end
      checks++;
      if ({busy_b, err_b} !== 3'b000) begin fails++; $display("FAIL bnd_timeout_err: busy/err got %b required 000", {busy_b, err_b}); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tick(3);
      test_reset();
      test_nominal();
      test_timeout();
      test_overrun();
      test_gating();
      test_abort();
      test_boundary();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
